// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: turns an Execute record into a byte/half/word
// load or store on a req/ack data-memory port and emits a write-back record.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [3:0]  mem_op,
    input  logic [4:0]  dest_reg,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_reg,
    output logic        wb_en,
    output logic        misaligned,
    output logic        bus_error,
    output logic [1:0]  dbg_state
);

    // Handshake: a record moves when valid and ready are both high in the same
    // cycle; valid may not depend on ready, and a presented record stays put.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state;
    logic [3:0]  op_q;
    logic [1:0]  off_q;
    logic [15:0] timer_q;

    logic        accept;
    logic        in_is_mem;
    logic        in_is_store;
    logic [1:0]  in_size;
    logic        in_misaligned;
    logic [3:0]  in_be;
    logic [31:0] in_wdata;

    logic        is_load_q;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_value;

    assign in_ready  = (state == IDLE) | ((state == RESP) & out_ready);
    assign accept    = in_valid & in_ready;
    assign dbg_state = state;

    assign in_is_mem   = (mem_op >= OP_LB) && (mem_op <= OP_SW);
    assign in_is_store = (mem_op >= OP_SB) && (mem_op <= OP_SW);

    always_comb begin
        in_size = SZ_WORD;
        case (mem_op)
            OP_LB, OP_LBU, OP_SB: in_size = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: in_size = SZ_HALF;
            default:              in_size = SZ_WORD;
        endcase
    end

    assign in_misaligned = in_is_mem &&
        (((in_size == SZ_HALF) && alu_result[0]) ||
         ((in_size == SZ_WORD) && (alu_result[1:0] != 2'b00)));

    // Big-endian lanes: address offset 0 lives in be[3] / wdata[31:24].
    always_comb begin
        in_be    = 4'b1111;
        in_wdata = store_data;
        if (in_is_store) begin
            case (in_size)
                SZ_BYTE: begin
                    in_be    = 4'b1000 >> alu_result[1:0];
                    in_wdata = {4{store_data[7:0]}};
                end
                SZ_HALF: begin
                    in_be    = alu_result[1] ? 4'b0011 : 4'b1100;
                    in_wdata = {2{store_data[15:0]}};
                end
                default: begin
                    in_be    = 4'b1111;
                    in_wdata = store_data;
                end
            endcase
        end
    end

    assign is_load_q = (op_q >= OP_LB) && (op_q <= OP_LW);

    always_comb begin
        ld_byte = dmem_rdata[31:24];
        case (off_q)
            2'd0:    ld_byte = dmem_rdata[31:24];
            2'd1:    ld_byte = dmem_rdata[23:16];
            2'd2:    ld_byte = dmem_rdata[15:8];
            default: ld_byte = dmem_rdata[7:0];
        endcase
    end

    assign ld_half = off_q[1] ? dmem_rdata[15:0] : dmem_rdata[31:16];

    always_comb begin
        load_value = dmem_rdata;
        case (op_q)
            OP_LB:   load_value = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  load_value = {24'd0, ld_byte};
            OP_LH:   load_value = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  load_value = {16'd0, ld_half};
            default: load_value = dmem_rdata;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            op_q       <= 4'd0;
            off_q      <= 2'd0;
            timer_q    <= 16'd0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_wdata <= 32'd0;
            dmem_be    <= 4'd0;
            out_valid  <= 1'b0;
            wb_data    <= 32'd0;
            wb_reg     <= 5'd0;
            wb_en      <= 1'b0;
            misaligned <= 1'b0;
            bus_error  <= 1'b0;
        end else if (accept) begin
            op_q       <= mem_op;
            off_q      <= alu_result[1:0];
            timer_q    <= 16'd0;
            wb_reg     <= dest_reg;
            wb_data    <= alu_result;
            misaligned <= 1'b0;
            bus_error  <= 1'b0;
            if (!in_is_mem) begin
                state     <= RESP;
                out_valid <= 1'b1;
                wb_en     <= (dest_reg != 5'd0);
            end else if (in_misaligned) begin
                state      <= RESP;
                out_valid  <= 1'b1;
                wb_en      <= 1'b0;
                misaligned <= 1'b1;
            end else begin
                state      <= REQ;
                out_valid  <= 1'b0;
                wb_en      <= 1'b0;
                dmem_req   <= 1'b1;
                dmem_we    <= in_is_store;
                dmem_addr  <= {alu_result[31:2], 2'b00};
                dmem_be    <= in_be;
                dmem_wdata <= in_wdata;
            end
        end else begin
            case (state)
                REQ: begin
                    // An ack in the expiry cycle still completes normally.
                    if (dmem_ack) begin
                        dmem_req  <= 1'b0;
                        state     <= RESP;
                        out_valid <= 1'b1;
                        if (is_load_q) begin
                            wb_data <= load_value;
                            wb_en   <= (wb_reg != 5'd0);
                        end else begin
                            wb_en <= 1'b0;
                        end
                    end else if (timer_q == TIMER_LAST) begin
                        dmem_req  <= 1'b0;
                        state     <= RESP;
                        out_valid <= 1'b1;
                        bus_error <= 1'b1;
                        wb_en     <= 1'b0;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                RESP: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a byte-level model predicts every
// write-back record and memory request, checked each cycle against the DUT.
`timescale 1ns/1ps
module tb_mem_access_stage;

    localparam int T = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [3:0]  mem_op;
    logic [4:0]  dest_reg;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_reg;
    logic        wb_en;
    logic        misaligned;
    logic        bus_error;
    logic [1:0]  dbg_state;

    mem_access_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .store_data(store_data),
        .mem_op(mem_op), .dest_reg(dest_reg),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_data(wb_data), .wb_reg(wb_reg), .wb_en(wb_en),
        .misaligned(misaligned), .bus_error(bus_error),
        .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        en;
        logic        mis;
        logic        berr;
    } wb_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic        we;
    } mem_t;

    wb_t  exp_q[$];
    mem_t mem_q[$];
    realtime pop_t[$];

    int vectors = 0;
    int errors  = 0;

    logic [31:0] mem_rdata = 32'd0;
    int ack_delay = 1;
    bit no_ack    = 1'b0;
    bit stray_ack = 1'b0;
    int last_run  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    function automatic int op_bytes(input logic [3:0] op);
        case (op)
            4'd1, 4'd2, 4'd6: return 1;
            4'd3, 4'd4, 4'd7: return 2;
            4'd5, 4'd8:       return 4;
            default:          return 0;
        endcase
    endfunction

    function automatic bit op_store(input logic [3:0] op);
        return (op >= 4'd6) && (op <= 4'd8);
    endfunction

    function automatic wb_t model_wb(input logic [3:0] op, input logic [31:0] addr,
                                     input logic [4:0] dest, input logic [31:0] rdata,
                                     input bit timed_out);
        wb_t r;
        int n;
        int off;
        logic [63:0] val;
        logic [7:0] b[4];
        n = op_bytes(op);
        off = int'(addr[1:0]);
        r.data = addr; r.rd = dest; r.en = 1'b0; r.mis = 1'b0; r.berr = 1'b0;
        if (n == 0) begin
            r.en = (dest != 5'd0);
            return r;
        end
        if ((off % n) != 0) begin
            r.mis = 1'b1;
            return r;
        end
        if (timed_out) begin
            r.berr = 1'b1;
            return r;
        end
        if (!op_store(op)) begin
            for (int i = 0; i < 4; i++) b[i] = rdata[31 - 8*i -: 8];
            val = 64'd0;
            for (int i = 0; i < n; i++) val = (val << 8) | 64'(b[off + i]);
            if ((op == 4'd1 || op == 4'd3) && val[8*n - 1]) val = val | (~64'd0 << (8*n));
            r.data = val[31:0];
            r.en = (dest != 5'd0);
        end
        return r;
    endfunction

    function automatic mem_t model_mem(input logic [3:0] op, input logic [31:0] addr,
                                       input logic [31:0] sd, input logic [31:0] rdata);
        mem_t m;
        int n;
        int off;
        int k;
        n = op_bytes(op);
        off = int'(addr[1:0]);
        m.addr = {addr[31:2], 2'b00};
        m.we = op_store(op);
        m.rdata = rdata;
        m.be = 4'b1111;
        m.wdata = 32'd0;
        if (m.we) begin
            for (int i = 0; i < 4; i++) begin
                m.be[3 - i] = (i >= off) && (i < off + n);
                k = n - 1 - (i % n);
                m.wdata[31 - 8*i -: 8] = sd[8*k +: 8];
            end
        end
        return m;
    endfunction

    // ---------------- drivers ----------------
    task automatic send(input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [4:0] dest);
        wb_t w;
        int n;
        w = model_wb(op, addr, dest, mem_rdata, no_ack);
        exp_q.push_back(w);
        if (op_bytes(op) != 0 && !w.mis) mem_q.push_back(model_mem(op, addr, sd, mem_rdata));
        in_valid = 1'b1; mem_op = op; alu_result = addr; store_data = sd; dest_reg = dest;
        @(negedge clock);
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("accept", {31'd0, in_ready}, 32'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        @(posedge clock);
        #1;
    endtask

    // ---------------- memory responder ----------------
    initial begin : responder
        int run;
        mem_t cur;
        bit ack_now;
        run = 0;
        cur = '0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'd0;
        forever begin
            @(negedge clock);
            ack_now = 1'b0;
            if (reset) begin
                run = 0;
            end else if (dmem_req) begin
                if (run == 0) begin
                    if (mem_q.size() == 0) begin
                        chk("unexpected_req", 32'd1, 32'd0);
                        cur = '0;
                    end else begin
                        cur = mem_q.pop_front();
                        chk("dmem_addr", dmem_addr, cur.addr);
                        chk("dmem_we", {31'd0, dmem_we}, {31'd0, cur.we});
                        chk("dmem_be", {28'd0, dmem_be}, {28'd0, cur.be});
                        if (cur.we) chk("dmem_wdata", dmem_wdata, cur.wdata);
                    end
                end
                run++;
                if (!no_ack && run == ack_delay) ack_now = 1'b1;
            end else begin
                if (run != 0) last_run = run;
                run = 0;
            end
            if (stray_ack) ack_now = 1'b1;
            dmem_ack = ack_now;
            dmem_rdata = ack_now ? cur.rdata : $urandom;
        end
    end

    // ---------------- compare process ----------------
    initial begin : compare
        wb_t h;
        forever begin
            @(negedge clock);
            if (!reset && out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    h = exp_q[0];
                    chk("wb_data", wb_data, h.data);
                    chk("wb_reg", {27'd0, wb_reg}, {27'd0, h.rd});
                    chk("wb_en", {31'd0, wb_en}, {31'd0, h.en});
                    chk("misaligned", {31'd0, misaligned}, {31'd0, h.mis});
                    chk("bus_error", {31'd0, bus_error}, {31'd0, h.berr});
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        pop_t.push_back($realtime);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    logic [3:0]  t_op[10]   = '{4'd6, 4'd6, 4'd3, 4'd3, 4'd4, 4'd8, 4'd5, 4'd3, 4'd7, 4'd12};
    logic [31:0] t_addr[10] = '{32'h10, 32'h13, 32'h20, 32'h22, 32'h22, 32'h30, 32'h34, 32'h21, 32'h23, 32'h99};
    logic [31:0] t_rd[10]   = '{32'h0, 32'h0, 32'h8001_7FFF, 32'h8001_7FFF, 32'h0000_8001,
                                32'h0, 32'h1234_5678, 32'h0, 32'h0, 32'h0};
    logic [4:0]  t_dst[10]  = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd0, 5'd8, 5'd9, 5'd7};

    initial begin : main
        wb_t  pw;
        mem_t pm;
        reset = 1'b1; in_valid = 1'b0; alu_result = 32'd0; store_data = 32'd0;
        mem_op = 4'd0; dest_reg = 5'd0; out_ready = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'd0);
        chk("rst_dmem_wdata", dmem_wdata, 32'd0);
        chk("rst_dmem_be", {28'd0, dmem_be}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_reg", {27'd0, wb_reg}, 32'd0);
        chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
        chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
        chk("rst_bus_error", {31'd0, bus_error}, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // model pins against hand-computed values
        pw = model_wb(4'd0, 32'h1234, 5'd5, 32'd0, 1'b0);
        chk("pin_none_data", pw.data, 32'h0000_1234);
        chk("pin_none_en", {31'd0, pw.en}, 32'd1);
        pw = model_wb(4'd1, 32'h100, 5'd1, 32'h80FF_0000, 1'b0);
        chk("pin_lb", pw.data, 32'hFFFF_FF80);
        pw = model_wb(4'd2, 32'h101, 5'd1, 32'h80FF_0000, 1'b0);
        chk("pin_lbu", pw.data, 32'h0000_00FF);
        pm = model_mem(4'd7, 32'h202, 32'h0000_ABCD, 32'd0);
        chk("pin_sh_addr", pm.addr, 32'h0000_0200);
        chk("pin_sh_be", {28'd0, pm.be}, 32'h3);
        chk("pin_sh_wdata", pm.wdata, 32'hABCD_ABCD);
        pw = model_wb(4'd5, 32'h103, 5'd1, 32'd0, 1'b0);
        chk("pin_lw_mis", {31'd0, pw.mis}, 32'd1);

        // NONE back-to-back, one record per cycle
        pop_t.delete();
        send(4'd0, 32'h0000_1234, 32'd0, 5'd5);
        send(4'd0, 32'h0000_5678, 32'd0, 5'd0);
        wait_drain();
        chk("none_pops", pop_t.size(), 2);
        if (pop_t.size() == 2) chk("no_bubble", 32'(int'(pop_t[1] - pop_t[0])), 32'd10);

        // byte loads, ack on the third request cycle
        ack_delay = 3;
        mem_rdata = 32'h80FF_0000;
        send(4'd1, 32'h100, 32'd0, 5'd10);
        send(4'd2, 32'h101, 32'd0, 5'd11);
        wait_drain();

        // SH with zero-wait memory
        ack_delay = 1;
        send(4'd7, 32'h202, 32'h0000_ABCD, 5'd12);
        wait_drain();

        // zero-wait load: two cycles from accept to out_valid
        mem_rdata = 32'hA5A5_0F0F;
        send(4'd5, 32'h300, 32'd0, 5'd13);
        @(negedge clock);
        chk("zw_req_cycle_ov", {31'd0, out_valid}, 32'd0);
        chk("zw_req_cycle_req", {31'd0, dmem_req}, 32'd1);
        @(negedge clock);
        chk("zw_resp_ov", {31'd0, out_valid}, 32'd1);
        chk("zw_resp_req", {31'd0, dmem_req}, 32'd0);
        wait_drain();

        // misaligned LW: no request, record next cycle
        send(4'd5, 32'h103, 32'd0, 5'd14);
        @(negedge clock);
        chk("mis_ov", {31'd0, out_valid}, 32'd1);
        chk("mis_flag", {31'd0, misaligned}, 32'd1);
        chk("mis_req", {31'd0, dmem_req}, 32'd0);
        wait_drain();

        // lane/extension table
        for (int i = 0; i < 10; i++) begin
            ack_delay = (i % 3) + 1;
            mem_rdata = t_rd[i];
            send(t_op[i], t_addr[i], 32'hCAFE_F00D ^ 32'(i), t_dst[i]);
        end
        wait_drain();

        // timeout, then a stray ack in IDLE
        no_ack = 1'b1;
        last_run = 0;
        send(4'd5, 32'h400, 32'd0, 5'd15);
        wait_drain();
        @(negedge clock);
        chk("timeout_req_cycles", 32'(last_run), 32'(T));
        no_ack = 1'b0;
        @(posedge clock); #1;
        stray_ack = 1'b1;
        @(posedge clock); #1;
        stray_ack = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("stray_ack_ov", {31'd0, out_valid}, 32'd0);
        @(posedge clock); #1;

        // reset during REQ, then a normal LW
        no_ack = 1'b1;
        send(4'd5, 32'h500, 32'd0, 5'd16);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        exp_q.delete();
        mem_q.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        no_ack = 1'b0;
        @(negedge clock);
        chk("rst_mid_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_mid_ov", {31'd0, out_valid}, 32'd0);
        @(posedge clock); #1;
        ack_delay = 2;
        mem_rdata = 32'hDEAD_BEEF;
        send(4'd5, 32'h504, 32'd0, 5'd17);
        wait_drain();

        // backpressure: record held for five cycles
        out_ready = 1'b0;
        send(4'd0, 32'h0000_0077, 32'd0, 5'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_wb_data", wb_data, 32'h0000_0077);
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
        wait_drain();

        chk("mem_q_empty", mem_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
